// File: rtl/parameters.sv
// ALU control codes shared by the decoder and the execution unit.
`ifndef ALU_PARAMETERS_SV
`define ALU_PARAMETERS_SV
`define ALU_AND     4'b0000
`define ALU_OR      4'b0001
`define ALU_ADD     4'b0010
`define ALU_SUB     4'b0110
`define ALU_INVALID 4'b1000
`endif

// File: rtl/alu_exec.sv
// Two-stage valid/ready ALU execution unit: stage 1 captures op/operands, stage 2 holds result and flags.
// Optional signed-overflow detection is enabled by defining ALU_OVF_EN.
`ifndef ALU_PARAMETERS_SV
`define ALU_PARAMETERS_SV
`define ALU_AND     4'b0000
`define ALU_OR      4'b0001
`define ALU_ADD     4'b0010
`define ALU_SUB     4'b0110
`define ALU_INVALID 4'b1000
`endif

module alu_exec #(
  parameter int WIDTH     = 32,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_alucontrol,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_result,
  output logic                 out_zero,
  output logic                 out_ovf,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

  logic                 s1_valid_q, s1_valid_d;
  logic [3:0]           s1_op_q, s1_op_d;
  logic [WIDTH-1:0]     s1_a_q, s1_a_d;
  logic [WIDTH-1:0]     s1_b_q, s1_b_d;

  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     out_result_q, out_result_d;
  logic                 out_zero_q, out_zero_d;
  logic                 out_ovf_q, out_ovf_d;
  logic                 out_err_q, out_err_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  logic                 s2_free;
  logic                 s1_move;
  logic [WIDTH-1:0]     exe_result;
  logic                 exe_err;
  logic                 exe_ovf;

  assign s2_free  = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_free;
  assign s1_move  = s1_valid_q && s2_free;

  always_comb begin
    exe_result = '0;
    exe_err    = 1'b0;
    exe_ovf    = 1'b0;
    case (s1_op_q)
      `ALU_ADD: begin
        exe_result = s1_a_q + s1_b_q;
`ifdef ALU_OVF_EN
        exe_ovf = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) &&
                  (exe_result[WIDTH-1] != s1_a_q[WIDTH-1]);
`endif
      end
      `ALU_SUB: begin
        exe_result = s1_a_q - s1_b_q;
`ifdef ALU_OVF_EN
        exe_ovf = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) &&
                  (exe_result[WIDTH-1] != s1_a_q[WIDTH-1]);
`endif
      end
      `ALU_AND: exe_result = s1_a_q & s1_b_q;
      `ALU_OR:  exe_result = s1_a_q | s1_b_q;
      default:  exe_err    = 1'b1;
    endcase
  end

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_op_d      = s1_op_q;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_zero_d   = out_zero_q;
    out_ovf_d    = out_ovf_q;
    out_err_d    = out_err_q;
    err_count_d  = err_count_q;

    // A fresh capture may overwrite stage 1 in the same cycle it drains.
    if (in_valid && in_ready) begin
      s1_valid_d = 1'b1;
      s1_op_d    = in_alucontrol;
      s1_a_d     = in_a;
      s1_b_d     = in_b;
    end else if (s1_move) begin
      s1_valid_d = 1'b0;
    end

    if (s1_move) begin
      out_valid_d  = 1'b1;
      out_result_d = exe_result;
      out_zero_d   = (exe_result == '0);
      out_ovf_d    = exe_ovf;
      out_err_d    = exe_err;
      if (exe_err && (err_count_q != ERR_MAX)) begin
        err_count_d = err_count_q + 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_op_q      <= '0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_zero_q   <= 1'b0;
      out_ovf_q    <= 1'b0;
      out_err_q    <= 1'b0;
      err_count_q  <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_op_q      <= s1_op_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_zero_q   <= out_zero_d;
      out_ovf_q    <= out_ovf_d;
      out_err_q    <= out_err_d;
      err_count_q  <= err_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_zero   = out_zero_q;
  assign out_ovf    = out_ovf_q;
  assign out_err    = out_err_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_alu_exec.sv
// Directed self-checking bench for alu_exec; overflow expectations follow ALU_OVF_EN.
module tb_alu_exec;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_INV = 4'b1000;
  localparam logic [3:0] OP_F   = 4'hF;

`ifdef ALU_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_alucontrol;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_ovf;
  logic        out_err;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_fail   = 0;

  alu_exec #(.WIDTH(32), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_alucontrol(in_alucontrol),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_ovf(out_ovf), .out_err(out_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid      = 1'b1;
    in_alucontrol = op;
    in_a          = a;
    in_b          = b;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] res, input logic zero,
                         input logic ovf, input logic err);
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_result"}, out_result, res);
    chk({tag, "_zero"}, out_zero, zero);
    chk({tag, "_ovf"}, out_ovf, ovf);
    chk({tag, "_err"}, out_err, err);
    $display("result %s: %h zero=%0b ovf=%0b err=%0b", tag, out_result, out_zero, out_ovf, out_err);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_alucontrol = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_result", out_result, 32'h0);
    chk("rst_flags", {out_zero, out_ovf, out_err}, 3'b000);
    chk("rst_errcnt", err_count, 8'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    tick();

    // ADD 5+7: out_valid after the second edge
    issue(OP_ADD, 32'd5, 32'd7);
    tick();
    in_valid = 1'b0;
    chk("add_lat1", out_valid, 1'b0);
    tick();
    chk_out("add", 32'd12, 1'b0, 1'b0, 1'b0);
    tick();
    chk("add_drain", out_valid, 1'b0);

    // back-to-back SUBs
    issue(OP_SUB, 32'd9, 32'd9);
    tick();
    issue(OP_SUB, 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
    chk_out("sub0", 32'h0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("subm1", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    tick();
    chk("sub_drain", out_valid, 1'b0);

    // back-pressure
    issue(OP_AND, 32'h0000_F0F0, 32'h0000_0FF0);
    tick();
    issue(OP_OR, 32'd1, 32'd2);
    out_ready = 1'b0;
    tick();
    issue(OP_ADD, 32'd100, 32'd23);
    #1;
    chk("stall_in_ready", in_ready, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_result", out_result, 32'h0000_00F0);
      chk("stall_in_ready_hold", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", in_ready, 1'b1);
    chk_out("and", 32'h0000_00F0, 1'b0, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    chk_out("or", 32'd3, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("third", 32'd123, 1'b0, 1'b0, 1'b0);
    tick();
    chk("third_drain", out_valid, 1'b0);

    // 300 invalid ops, saturating counter
    for (int i = 0; i < 300; i++) begin
      issue(((i % 2) == 0) ? OP_INV : OP_F, 32'h1234_5678 + i, 32'd3);
      tick();
      chk("inv_errcnt", err_count, (i > 255) ? 64'd255 : 64'(i));
      if (i >= 1) begin
        chk("inv_valid", out_valid, 1'b1);
        chk("inv_result", out_result, 32'h0);
        chk("inv_flags", {out_zero, out_ovf, out_err}, 3'b101);
      end
    end
    in_valid = 1'b0;
    tick();
    chk_out("inv_last", 32'h0, 1'b1, 1'b0, 1'b1);
    chk("inv_sat", err_count, 8'd255);
    tick();
    chk("inv_drain", out_valid, 1'b0);

    // signed overflow cases
    issue(OP_ADD, 32'h7FFF_FFFF, 32'd1);
    tick();
    in_valid = 1'b0;
    tick();
    chk_out("add_ovf", 32'h8000_0000, 1'b0, OVF_ON, 1'b0);
    issue(OP_SUB, 32'h8000_0000, 32'd1);
    tick();
    in_valid = 1'b0;
    tick();
    chk_out("sub_ovf", 32'h7FFF_FFFF, 1'b0, OVF_ON, 1'b0);
    issue(OP_ADD, 32'hFFFF_FFFF, 32'd1);
    tick();
    in_valid = 1'b0;
    tick();
    chk_out("add_noovf", 32'h0, 1'b1, 1'b0, 1'b0);
    tick();

    // reset with both stages full
    out_ready = 1'b0;
    issue(OP_ADD, 32'd1, 32'd1);
    tick();
    issue(OP_OR, 32'd4, 32'd8);
    tick();
    in_valid = 1'b0;
    chk("full_valid", out_valid, 1'b1);
    chk("full_in_ready", in_ready, 1'b0);
    rst_n = 1'b0;
    tick();
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_errcnt", err_count, 8'd0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_result", out_result, 32'h0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("post_rst_valid1", out_valid, 1'b0);
    tick();
    chk("post_rst_valid2", out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Two-stage pipelined execution unit that consumes the 4-bit alucontrol code produced by the ALU control decoder, together with two operands.
- Produces the result plus zero, overflow and invalid-op flags.
- Sits between decode/register read and writeback/branch resolution in the datapath.
- Uses valid/ready handshakes on both sides so a stalling consumer back-pressures issue.

Parameters:
- WIDTH, 32, operand/result width in bits.
- ERR_CNT_W, 8, width of the saturating invalid-op counter.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  unit can accept the request this cycle
- in_alucontrol  input  4  op code; ALU_ADD/ALU_SUB/ALU_AND/ALU_OR/ALU_INVALID macros from rtl/parameters.sv
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- out_result  output  WIDTH  result
- out_zero  output  1  out_result == 0
- out_ovf  output  1  signed overflow (optional feature)
- out_err  output  1  op code was not ADD/SUB/AND/OR
- err_count  output  ERR_CNT_W  saturating count of accepted invalid ops

Behaviour:
- Clocking and reset
  - Single clock domain.
  - All state is cleared when rst_n is sampled 0 on a rising edge.
  - Reset values: s1_valid=0, out_valid=0, out_result=0, out_zero=0, out_ovf=0, out_err=0, err_count=0.
  - Reset mid-operation discards both stages with no output.
- Handshakes
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Stage 1 (capture)
  - Registers op, a and b on an input transfer.
  - s2_free = !out_valid || out_ready.
  - in_ready = !s1_valid || s2_free (combinational, no dependence on in_valid).
- Stage 2 (execute/hold)
  - When s1_valid && s2_free, stage 2 loads the computed result and flags and sets out_valid=1.
  - Otherwise, if out_ready, out_valid clears.
- Latency and throughput
  - 2 cycles from input transfer to out_valid with out_ready held high.
  - Throughput is 1 op per cycle.
- Output stability
  - While out_valid && !out_ready, out_result and all flags hold stable.
  - Stage 1 holds its contents.
  - in_ready drops once stage 1 is occupied.
- Simultaneous events
  - Output transfer and stage1→stage2 move in the same cycle: allowed (bubble-free).
  - Input transfer and stage1 drain in the same cycle: allowed.
- Arithmetic
  - ADD: a+b, modulo 2^WIDTH.
  - SUB: a-b, two's complement, modulo 2^WIDTH.
  - AND: a&b.
  - OR: a|b.
  - Carry out is discarded.
- Invalid op (any other code, including ALU_INVALID)
  - out_result=0, out_err=1, out_zero=1, out_ovf=0.
- Valid ops
  - out_err=0.
  - out_zero = (out_result==0).
- err_count
  - Increments when an invalid op moves into stage 2.
  - Saturates at 2^ERR_CNT_W-1; no wrap.

Optional Feature:
- Macro: ALU_OVF_EN.
- Defined:
  - out_ovf=1 for ADD when a and b have equal sign and the result sign differs.
  - out_ovf=1 for SUB when a and b signs differ and the result sign differs from a.
  - out_ovf=0 for AND/OR/invalid.
  - Registered with the result.
- Undefined:
  - out_ovf is tied to 0.
  - No overflow logic is synthesised.
  - Port remains present.

Test Plan:
- Reset, then ADD a=5 b=7 with out_ready=1 → out_valid 2 cycles later, result=12, zero=0, err=0, ovf=0.
- SUB a=9 b=9 then SUB a=0 b=1 back-to-back → results 0 (zero=1) then 0xFFFFFFFF (zero=0) on consecutive cycles.
- AND 0xF0F0 & 0x0FF0, then hold out_ready=0 for 5 cycles while issuing OR 1|2 and a third op:
  - result 0x00F0 held stable.
  - in_ready falls after the second op is captured.
  - On release, 0x00F0 then 3 then the third result, none lost or duplicated.
- ALU_INVALID and code 4'hF issued 300 times → out_err=1, result=0 each time; err_count saturates at 255.
- With ALU_OVF_EN:
  - ADD 0x7FFFFFFF+1 → ovf=1, result 0x80000000.
  - SUB 0x80000000-1 → ovf=1.
  - Without the macro, both give ovf=0.
- Assert rst_n=0 for one cycle with both stages full → out_valid=0 next cycle, err_count=0, in_ready=1.
